// File: rtl/nch_trig_pkg.sv
// Shared types and constants for the N-channel trigger/capture controller.
//   MODE_*  : trigger-mode encodings carried on mode_i
//   state_e : capture FSM states
package nch_trig_pkg;

    localparam logic [1:0] MODE_OR     = 2'b00;  // OR of per-channel internal edges
    localparam logic [1:0] MODE_MULT   = 2'b01;  // hit multiplicity reaches min_mult
    localparam logic [1:0] MODE_EXT    = 2'b10;  // external trigger only
    localparam logic [1:0] MODE_EXT_OR = 2'b11;  // external OR internal

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DEAD    = 2'd2
    } state_e;

endpackage

// File: rtl/nch_delay_line.sv
// Pretrigger delay line: a DEPTH-stage shift register with async clear.
// Ports:
//   clk, rst_n : clock, async active-low clear of every stage
//   din_i      : sample word entering the line each cycle
//   dout_o     : din_i delayed by exactly DEPTH cycles (register output)
module nch_delay_line #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned DEPTH = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    // Shift one stage per cycle; stage DEPTH-1 holds the sample from DEPTH cycles ago.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= din_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/nch_trig_capture.sv
// N-channel self/external-triggered waveform capture controller.
// Ports:
//   clk, rst_n      : sample clock, async active-low reset
//   adc_data_i      : live samples, channel k at [k*D_WIDTH +: D_WIDTH]
//   baseline_i      : per-channel baselines, same packing
//   thres_i         : threshold above baseline, common to all channels
//   mode_i          : trigger mode (see nch_trig_pkg MODE_*)
//   min_mult_i      : multiplicity required in MODE_MULT (0 behaves as 1)
//   arm_i           : enables acceptance of new triggers
//   ext_trig_i      : asynchronous external trigger
//   fifo_full_i     : downstream FIFO full
//   wr_data_o       : samples delayed by PRE_DEPTH cycles
//   wr_en_o         : FIFO write strobe during the capture window
//   trig_mask_o     : channels over threshold on the last accepted trigger
//   busy_o          : controller not idle
//   trig_cnt_o      : accepted triggers (saturating)
//   miss_cnt_o      : triggers ignored while busy or disarmed (saturating)
//   drop_cnt_o      : window samples dropped on FIFO full (saturating)
module nch_trig_capture
    import nch_trig_pkg::*;
#(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned D_WIDTH   = 14,
    parameter int unsigned PRE_DEPTH = 100,
    parameter int unsigned WIN_LEN   = 256,
    parameter int unsigned DEAD_LEN  = 16,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_CH*D_WIDTH-1:0]   adc_data_i,
    input  logic [N_CH*D_WIDTH-1:0]   baseline_i,
    input  logic [D_WIDTH-1:0]        thres_i,
    input  logic [1:0]                mode_i,
    input  logic [$clog2(N_CH+1)-1:0] min_mult_i,
    input  logic                      arm_i,
    input  logic                      ext_trig_i,
    input  logic                      fifo_full_i,
    output logic [N_CH*D_WIDTH-1:0]   wr_data_o,
    output logic                      wr_en_o,
    output logic [N_CH-1:0]           trig_mask_o,
    output logic                      busy_o,
    output logic [CNT_W-1:0]          trig_cnt_o,
    output logic [CNT_W-1:0]          miss_cnt_o,
    output logic [CNT_W-1:0]          drop_cnt_o
);

    localparam int unsigned MULT_W    = $clog2(N_CH + 1);
    localparam int unsigned FILL_W    = $clog2(PRE_DEPTH + 1);
    localparam int unsigned TMR_MAX   = (WIN_LEN > DEAD_LEN) ? WIN_LEN : DEAD_LEN;
    localparam int unsigned TMR_W     = $clog2(TMR_MAX + 1);
    localparam int unsigned WIN_LAST  = WIN_LEN - 1;
    localparam int unsigned DEAD_LAST = (DEAD_LEN > 0) ? DEAD_LEN - 1 : 0;

    function automatic logic [MULT_W-1:0] popcount(input logic [N_CH-1:0] v);
        logic [MULT_W-1:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cnt = cnt + MULT_W'(v[i]);
        end
        return cnt;
    endfunction

    state_e              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [FILL_W-1:0]   fill_q;
    logic [N_CH-1:0]     hit_c, hit_q, hit_prev_q;
    logic [1:0]          ext_sync_q;
    logic                ext_r_q, ext_prev_q, ext_edge_q;
    logic                wr_en_q, busy_q, wr_en_d;
    logic [N_CH-1:0]     mask_q;
    logic [CNT_W-1:0]    trig_cnt_q, miss_cnt_q, drop_cnt_q;
    logic                filled_c, int_or_c, mult_trig_c, trig_any_c;
    logic                accept_c, miss_c, drop_c;
    logic [MULT_W-1:0]   mult_thr_c;

    nch_delay_line #(
        .WIDTH (N_CH * D_WIDTH),
        .DEPTH (PRE_DEPTH)
    ) u_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (adc_data_i),
        .dout_o (wr_data_o)
    );

    // Discriminator in D_WIDTH+1 bits so baseline+threshold cannot wrap.
    always_comb begin
        hit_c = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            hit_c[k] = ({1'b0, adc_data_i[k*D_WIDTH +: D_WIDTH]} >
                        ({1'b0, baseline_i[k*D_WIDTH +: D_WIDTH]} + {1'b0, thres_i}));
        end
    end

    // Trigger sources and mode selection.
    always_comb begin
        filled_c    = (fill_q == FILL_W'(PRE_DEPTH));
        int_or_c    = |(hit_q & ~hit_prev_q);
        mult_thr_c  = (min_mult_i == '0) ? MULT_W'(1) : min_mult_i;
        mult_trig_c = (popcount(hit_q) >= mult_thr_c) && (popcount(hit_prev_q) < mult_thr_c);
        trig_any_c  = 1'b0;
        case (mode_i)
            MODE_OR:     trig_any_c = int_or_c;
            MODE_MULT:   trig_any_c = mult_trig_c;
            MODE_EXT:    trig_any_c = ext_edge_q;
            MODE_EXT_OR: trig_any_c = int_or_c | ext_edge_q;
            default:     trig_any_c = 1'b0;
        endcase
    end

    // Capture FSM next state, window/dead timer and per-cycle events.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        accept_c = 1'b0;
        miss_c   = trig_any_c && ((state_q != IDLE) || (filled_c && !arm_i));
        unique case (state_q)
            IDLE: begin
                if (trig_any_c && arm_i && filled_c) begin
                    state_d  = CAPTURE;
                    tmr_d    = '0;
                    accept_c = 1'b1;
                end
            end
            CAPTURE: begin
                if (tmr_q == TMR_W'(WIN_LAST)) begin
                    tmr_d   = '0;
                    state_d = (DEAD_LEN == 0) ? IDLE : DEAD;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            DEAD: begin
                if (tmr_q == TMR_W'(DEAD_LAST)) begin
                    tmr_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
            end
        endcase
        // Strobe is registered, so it is decided on the next state.
        wr_en_d = (state_d == CAPTURE) && !fifo_full_i;
        drop_c  = (state_d == CAPTURE) && fifo_full_i;
    end

    // FSM, discriminator pipeline, fill counter and external-trigger path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            fill_q     <= '0;
            hit_q      <= '0;
            hit_prev_q <= '0;
            ext_sync_q <= '0;
            ext_r_q    <= '0;
            ext_prev_q <= '0;
            ext_edge_q <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            if (!filled_c) begin
                fill_q <= fill_q + FILL_W'(1);
            end
            hit_q      <= hit_c;
            hit_prev_q <= hit_q;
            // 2-FF sync, retime, registered edge: lands 3 cycles behind an internal crossing.
            ext_sync_q <= {ext_sync_q[0], ext_trig_i};
            ext_r_q    <= ext_sync_q[1];
            ext_prev_q <= ext_r_q;
            ext_edge_q <= ext_r_q & ~ext_prev_q;
        end
    end

    // Registered outputs and saturating status counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            mask_q     <= '0;
            trig_cnt_q <= '0;
            miss_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_en_q <= wr_en_d;
            busy_q  <= (state_d != IDLE);
            if (accept_c) begin
                mask_q <= hit_q;
            end
            if (accept_c && (trig_cnt_q != '1)) begin
                trig_cnt_q <= trig_cnt_q + CNT_W'(1);
            end
            if (miss_c && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end
            if (drop_c && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
        end
    end

    assign wr_en_o     = wr_en_q;
    assign busy_o      = busy_q;
    assign trig_mask_o = mask_q;
    assign trig_cnt_o  = trig_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule
